// File: rtl/serial_subtractor_if.sv
// serial_subtractor_if: request/result bus of the bit-serial subtractor.
// The ovf signal exists only when SERIAL_SUB_OVF_EN is defined.
interface serial_subtractor_if #(parameter int WIDTH = 4);
    logic             start;
    logic             start_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] diff;
    logic             borrow;
    logic             result_valid;
    logic             result_ready;
`ifdef SERIAL_SUB_OVF_EN
    logic             ovf;
    modport master (output start, a, b, result_ready,
                    input  start_ready, diff, borrow, result_valid, ovf);
    modport slave  (input  start, a, b, result_ready,
                    output start_ready, diff, borrow, result_valid, ovf);
`else
    modport master (output start, a, b, result_ready,
                    input  start_ready, diff, borrow, result_valid);
    modport slave  (input  start, a, b, result_ready,
                    output start_ready, diff, borrow, result_valid);
`endif
endinterface

// File: rtl/serial_subtractor.sv
// serial_subtractor: LSB-first bit-serial A - B with one full-subtractor cell and a borrow flop.
// Optional signed-overflow output enabled by SERIAL_SUB_OVF_EN.
module serial_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    serial_subtractor_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           r_state, w_next;
    logic [WIDTH-1:0] r_a, r_b, r_diff;
    logic [CW-1:0]    r_cnt;
    logic             r_borrow;
    logic             w_d, w_bout, w_last, w_accept;

    assign w_d      = r_a[0] ^ r_b[0] ^ r_borrow;
    assign w_bout   = (~r_a[0] & r_b[0]) | (~r_a[0] & r_borrow) | (r_b[0] & r_borrow);
    assign w_last   = r_cnt == CW'(WIDTH - 1);
    assign w_accept = (r_state == IDLE) && bus.start;

    always_comb begin
        w_next = r_state;
        w_next = w_accept                                ? SHIFT :
                 (r_state == SHIFT && w_last)            ? DONE  :
                 (r_state == DONE && bus.result_ready)   ? IDLE  : r_state;
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a      <= '0;
            r_b      <= '0;
            r_diff   <= '0;
            r_borrow <= 1'b0;
            r_cnt    <= '0;
        end else if (w_accept) begin
            r_a      <= bus.a;
            r_b      <= bus.b;
            r_diff   <= '0;
            r_borrow <= 1'b0;
            r_cnt    <= '0;
        end else if (r_state == SHIFT) begin
            r_a      <= r_a >> 1;
            r_b      <= r_b >> 1;
            r_diff   <= {w_d, r_diff[WIDTH-1:1]};
            r_borrow <= w_bout;
            r_cnt    <= r_cnt + CW'(1);
        end
    end

    assign bus.start_ready  = r_state == IDLE;
    assign bus.result_valid = r_state == DONE;
    assign bus.diff         = r_diff;
    assign bus.borrow       = r_borrow;

`ifdef SERIAL_SUB_OVF_EN
    logic r_ovf;

    // Borrow into the MSB is r_borrow on the last shift; its XOR with the MSB borrow-out flags signed overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                          r_ovf <= 1'b0;
        else if (w_accept)                   r_ovf <= 1'b0;
        else if (r_state == SHIFT && w_last) r_ovf <= r_borrow ^ w_bout;
    end

    assign bus.ovf = r_ovf;
`endif
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: randomized and directed checks of serial_subtractor against an arithmetic model.
module tb_serial_subtractor;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    serial_subtractor_if #(.WIDTH(4)) bus();

    serial_subtractor #(.WIDTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] m_diff(input logic [3:0] a, input logic [3:0] b);
        int r;
        r = (int'(a) - int'(b) + 16) % 16;
        return 4'(r);
    endfunction

    function automatic logic m_borrow(input logic [3:0] a, input logic [3:0] b);
        return int'(a) < int'(b);
    endfunction

    function automatic logic m_ovf(input logic [3:0] a, input logic [3:0] b);
        int sa, sb, r;
        sa = a[3] ? int'(a) - 16 : int'(a);
        sb = b[3] ? int'(b) - 16 : int'(b);
        r  = sa - sb;
        return (r < -8) || (r > 7);
    endfunction

    function automatic logic get_ovf();
`ifdef SERIAL_SUB_OVF_EN
        return bus.ovf;
`else
        return 1'b0;
`endif
    endfunction

    // Drives one request from IDLE and waits for the result; leaves it unconsumed.
    task automatic run_op(input logic [3:0] a, input logic [3:0] b, input bit scramble, input bit poke,
                          output logic [3:0] d, output logic br, output logic ov,
                          output int lat, output bit busy_ok);
        bus.a = a;
        bus.b = b;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        lat = 0;
        busy_ok = 1'b1;
        while (!bus.result_valid && lat < 20) begin
            if (bus.start_ready) busy_ok = 1'b0;
            if (scramble) begin
                bus.a = 4'($urandom_range(0, 15));
                bus.b = 4'($urandom_range(0, 15));
            end
            bus.start = poke ? 1'($urandom_range(0, 1)) : 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        bus.start = 1'b0;
        d  = bus.diff;
        br = bus.borrow;
        ov = get_ovf();
    endtask

    task automatic consume();
        bus.result_ready = 1'b1;
        @(posedge clk); #1;
        bus.result_ready = 1'b0;
    endtask

    task automatic test_reset();
        bus.start = 1'b0;
        bus.a = '0;
        bus.b = '0;
        bus.result_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.diff !== 4'h0 || bus.borrow !== 1'b0 || bus.result_valid !== 1'b0 || get_ovf() !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: diff=%h borrow=%b valid=%b ovf=%b, want 0 0 0 0",
                     bus.diff, bus.borrow, bus.result_valid, get_ovf());
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (bus.start_ready !== 1'b1 || bus.result_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: start_ready=%b valid=%b, want 1 0", bus.start_ready, bus.result_valid);
        end
    endtask

    task automatic test_directed();
        logic [3:0] ta [7] = '{4'd9, 4'd3, 4'd0, 4'd7, 4'd8, 4'd5, 4'd2};
        logic [3:0] tb [7] = '{4'd3, 4'd9, 4'd1, 4'd7, 4'd1, 4'd2, 4'd9};
        logic [3:0] d;
        logic br, ov;
        int lat;
        bit busy_ok;
        for (int i = 0; i < 7; i++) begin
            run_op(ta[i], tb[i], 1'b0, 1'b0, d, br, ov, lat, busy_ok);
            checks++;
            if (lat !== 4 || !busy_ok) begin
                errors++;
                $display("FAIL latency %0d-%0d: cycles=%0d busy_ok=%0b, want 4 1", ta[i], tb[i], lat, busy_ok);
            end
            checks++;
            if (d !== m_diff(ta[i], tb[i]) || br !== m_borrow(ta[i], tb[i])) begin
                errors++;
                $display("FAIL result %0d-%0d: diff=%h borrow=%b, want %h %b",
                         ta[i], tb[i], d, br, m_diff(ta[i], tb[i]), m_borrow(ta[i], tb[i]));
            end
`ifdef SERIAL_SUB_OVF_EN
            checks++;
            if (ov !== m_ovf(ta[i], tb[i])) begin
                errors++;
                $display("FAIL ovf %0d-%0d: ovf=%b, want %b", ta[i], tb[i], ov, m_ovf(ta[i], tb[i]));
            end
`endif
            consume();
            checks++;
            if (bus.result_valid !== 1'b0 || bus.start_ready !== 1'b1) begin
                errors++;
                $display("FAIL handback %0d-%0d: valid=%b start_ready=%b, want 0 1",
                         ta[i], tb[i], bus.result_valid, bus.start_ready);
            end
        end
    endtask

    task automatic test_random_operand_change();
        logic [3:0] a, b, d;
        logic br, ov;
        int lat;
        bit busy_ok;
        for (int i = 0; i < 24; i++) begin
            a = 4'($urandom_range(0, 15));
            b = 4'($urandom_range(0, 15));
            run_op(a, b, 1'b1, 1'b0, d, br, ov, lat, busy_ok);
            checks++;
            if (lat !== 4 || d !== m_diff(a, b) || br !== m_borrow(a, b) || ov !== (get_ovf() & m_ovf(a, b))) begin
                errors++;
                $display("FAIL random %0d-%0d: cycles=%0d diff=%h borrow=%b ovf=%b, want 4 %h %b %b",
                         a, b, lat, d, br, ov, m_diff(a, b), m_borrow(a, b), get_ovf() & m_ovf(a, b));
            end
            consume();
        end
    endtask

    task automatic test_backpressure();
        logic [3:0] d;
        logic br, ov;
        int lat;
        bit busy_ok;
        bit extra;
        run_op(4'd9, 4'd3, 1'b1, 1'b1, d, br, ov, lat, busy_ok);
        checks++;
        if (lat !== 4 || d !== 4'd6 || br !== 1'b0) begin
            errors++;
            $display("FAIL bp_result: cycles=%0d diff=%h borrow=%b, want 4 6 0", lat, d, br);
        end
        for (int i = 0; i < 10; i++) begin
            bus.start = 1'b1;
            bus.a = 4'($urandom_range(0, 15));
            bus.b = 4'($urandom_range(0, 15));
            @(posedge clk); #1;
            checks++;
            if (bus.result_valid !== 1'b1 || bus.diff !== 4'd6 || bus.borrow !== 1'b0 || bus.start_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold cycle %0d: valid=%b diff=%h borrow=%b start_ready=%b, want 1 6 0 0",
                         i, bus.result_valid, bus.diff, bus.borrow, bus.start_ready);
            end
        end
        // start coincides with result_ready in DONE: it must not launch a new operation
        bus.result_ready = 1'b1;
        @(posedge clk); #1;
        bus.result_ready = 1'b0;
        bus.start = 1'b0;
        extra = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (bus.result_valid !== 1'b0 || bus.start_ready !== 1'b1) extra = 1'b1;
            @(posedge clk); #1;
        end
        checks++;
        if (extra) begin
            errors++;
            $display("FAIL bp_no_second_result: valid=%b start_ready=%b, want 0 1", bus.result_valid, bus.start_ready);
        end
    endtask

    task automatic test_reset_mid();
        logic [3:0] d;
        logic br, ov;
        int lat;
        bit busy_ok;
        bus.a = 4'd3;
        bus.b = 4'd9;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.diff !== 4'h0 || bus.borrow !== 1'b0 || bus.result_valid !== 1'b0 || get_ovf() !== 1'b0) begin
            errors++;
            $display("FAIL midreset_outputs: diff=%h borrow=%b valid=%b ovf=%b, want 0 0 0 0",
                     bus.diff, bus.borrow, bus.result_valid, get_ovf());
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (bus.start_ready !== 1'b1 || bus.result_valid !== 1'b0) begin
            errors++;
            $display("FAIL midreset_release: start_ready=%b valid=%b, want 1 0", bus.start_ready, bus.result_valid);
        end
        run_op(4'd5, 4'd2, 1'b0, 1'b0, d, br, ov, lat, busy_ok);
        checks++;
        if (lat !== 4 || d !== 4'd3 || br !== 1'b0) begin
            errors++;
            $display("FAIL midreset_next: cycles=%0d diff=%h borrow=%b, want 4 3 0", lat, d, br);
        end
        consume();
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random_operand_change();
        test_backpressure();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
